rf_write_arbiter: RTL

- Shares the register file's single write port between two writeback requesters: src0 (ALU/execute result) and src1 (memory load return).
- Round-robin arbitration with a valid/ready handshake.
- The granted write is registered and driven onto the register file write port (wrEn, waddr, wdata, ppp) one cycle later.
- Sits between the writeback stage and the register file. It also filters writes to R0 and illegal participation codes.

---
 rtl/rf_write_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between the ALU (src0)
// and load-return (src1) writeback paths; filters R0 writes and illegal ppp codes.
module rf_write_arbiter #(
  parameter int NREGS  = 32,
  parameter int DWIDTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              src0_valid,
  output logic              src0_ready,
  input  logic [4:0]        src0_waddr,
  input  logic [DWIDTH-1:0] src0_wdata,
  input  logic [2:0]        src0_ppp,
  input  logic              src1_valid,
  output logic              src1_ready,
  input  logic [4:0]        src1_waddr,
  input  logic [DWIDTH-1:0] src1_wdata,
  input  logic [2:0]        src1_ppp,
  output logic              rf_wrEn,
  output logic [4:0]        rf_waddr,
  output logic [DWIDTH-1:0] rf_wdata,
  output logic [2:0]        rf_ppp,
  output logic              last_grant,
  output logic              err_ppp,
  output logic [7:0]        drop_cnt
);

  localparam logic [5:0] ADDR_END = 6'(NREGS);

  function automatic logic ppp_illegal(input logic [2:0] ppp);
    return (ppp >= 3'd5);
  endfunction

  // R0 is hardwired zero; addresses past the architected file are also discarded.
  function automatic logic addr_dropped(input logic [4:0] waddr);
    return (waddr == 5'd0) || ({1'b0, waddr} >= ADDR_END);
  endfunction

  logic              gnt0;
  logic              gnt1;
  logic              accept;
  logic [4:0]        sel_waddr;
  logic [DWIDTH-1:0] sel_wdata;
  logic [2:0]        sel_ppp;
  logic              sel_filtered;

  logic              rf_wr_en_d, rf_wr_en_q;
  logic [4:0]        rf_waddr_d, rf_waddr_q;
  logic [DWIDTH-1:0] rf_wdata_d, rf_wdata_q;
  logic [2:0]        rf_ppp_d,   rf_ppp_q;
  logic              last_grant_d, last_grant_q;
  logic              err_ppp_d,  err_ppp_q;
  logic [7:0]        drop_cnt_d, drop_cnt_q;

  // Grant: the source that did not win last time is favoured under contention.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset || hold) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end else if (src0_valid && src1_valid) begin
      gnt0 = last_grant_q;
      gnt1 = ~last_grant_q;
    end else begin
      gnt0 = src0_valid;
      gnt1 = src1_valid;
    end
  end

  // Select the accepted request's fields and classify it.
  always_comb begin
    accept       = gnt0 | gnt1;
    sel_waddr    = src0_waddr;
    sel_wdata    = src0_wdata;
    sel_ppp      = src0_ppp;
    if (gnt1) begin
      sel_waddr = src1_waddr;
      sel_wdata = src1_wdata;
      sel_ppp   = src1_ppp;
    end else begin
      sel_waddr = src0_waddr;
      sel_wdata = src0_wdata;
      sel_ppp   = src0_ppp;
    end
    sel_filtered = addr_dropped(sel_waddr) | ppp_illegal(sel_ppp);
  end

  // Next-state for the write port and status registers.
  always_comb begin
    rf_wr_en_d   = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    rf_ppp_d     = rf_ppp_q;
    last_grant_d = last_grant_q;
    err_ppp_d    = err_ppp_q;
    drop_cnt_d   = drop_cnt_q;
    if (accept) begin
      last_grant_d = gnt1;
      if (sel_filtered) begin
        rf_wr_en_d = 1'b0;
        err_ppp_d  = err_ppp_q | ppp_illegal(sel_ppp);
        if (drop_cnt_q != 8'hFF) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end else begin
          drop_cnt_d = drop_cnt_q;
        end
      end else begin
        rf_wr_en_d = 1'b1;
        rf_waddr_d = sel_waddr;
        rf_wdata_d = sel_wdata;
        rf_ppp_d   = sel_ppp;
      end
    end else begin
      rf_wr_en_d = 1'b0;
    end
  end

  // State registers; reset discards any write still registered for the port.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_wr_en_q   <= 1'b0;
      rf_waddr_q   <= 5'd0;
      rf_wdata_q   <= '0;
      rf_ppp_q     <= 3'd0;
      last_grant_q <= 1'b1;
      err_ppp_q    <= 1'b0;
      drop_cnt_q   <= 8'd0;
    end else begin
      rf_wr_en_q   <= rf_wr_en_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      rf_ppp_q     <= rf_ppp_d;
      last_grant_q <= last_grant_d;
      err_ppp_q    <= err_ppp_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign src0_ready = gnt0;
  assign src1_ready = gnt1;
  assign rf_wrEn    = rf_wr_en_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign rf_ppp     = rf_ppp_q;
  assign last_grant = last_grant_q;
  assign err_ppp    = err_ppp_q;
  assign drop_cnt   = drop_cnt_q;

endmodule
